spi_master_ctrl: RTL

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   Sequences one SPI word transfer: asserts chip select, waits a setup time,
//   enables an external SCLK generator, shifts DATA_WIDTH bits MSB first on
//   the edge pulses that generator reports, waits a hold time, releases chip
//   select and pulses doneOut with the received word.
//
// Ports
//   clkIn              system clock (only clock)
//   rstIn              synchronous active-high reset
//   startIn            transfer request, only looked at in IDLE
//   txDataIn           word to send, captured when startIn is accepted
//   risingEdgePulseIn  one-cycle pulse per SCLK rising edge
//   fallingEdgePulseIn one-cycle pulse per SCLK falling edge
//   misoIn             serial receive data
//   sclkEnOut          enable for the SCLK generator
//   csnOut             active-low chip select
//   mosiOut            serial transmit data (0 whenever csnOut=1)
//   rxDataOut          last received word, updated with doneOut
//   busyOut            high in every state except IDLE
//   doneOut            one-cycle completion pulse
//   dbg_state_out      current FSM state encoding (0 = IDLE)
//
// Request handshake: startIn acts as "valid" and busyOut=0 as "ready"; a
// request is accepted on a clock edge where startIn=1 and the FSM is in IDLE.
// Requests while busy are dropped, never queued.
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter logic        CPOL            = 1'b0,
  parameter logic        CPHA            = 1'b0,
  parameter int unsigned CS_SETUP_CYCLES = 4,
  parameter int unsigned CS_HOLD_CYCLES  = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  startIn,
  input  logic [DATA_WIDTH-1:0] txDataIn,
  input  logic                  risingEdgePulseIn,
  input  logic                  fallingEdgePulseIn,
  input  logic                  misoIn,
  output logic                  sclkEnOut,
  output logic                  csnOut,
  output logic                  mosiOut,
  output logic [DATA_WIDTH-1:0] rxDataOut,
  output logic                  busyOut,
  output logic                  doneOut,
  output logic [2:0]            dbg_state_out
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_TRANSFER = 3'd2,
    ST_CS_HOLD  = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int unsigned CNT_MAX = (CS_SETUP_CYCLES > CS_HOLD_CYCLES) ? CS_SETUP_CYCLES
                                                                       : CS_HOLD_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  csn_q, csn_d;
  logic                  sclk_en_q, sclk_en_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Leading edge is the first edge away from the SCLK idle level.
  logic lead_edge, trail_edge;
  assign lead_edge  = CPOL ? fallingEdgePulseIn : risingEdgePulseIn;
  assign trail_edge = CPOL ? risingEdgePulseIn  : fallingEdgePulseIn;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    sclk_en_d = sclk_en_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (startIn) begin
          state_d   = ST_CS_SETUP;
          tx_sr_d   = txDataIn;
          rx_sr_d   = '0;
          bit_cnt_d = '0;
          cnt_d     = '0;
          // CPHA=0 slaves sample on the very first edge, so the MSB must be
          // on the line for the whole setup time. CPHA=1 drives it on the
          // first leading edge instead.
          mosi_d    = CPHA ? 1'b0 : txDataIn[DATA_WIDTH-1];
        end
      end

      ST_CS_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d   = ST_TRANSFER;
          sclk_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_TRANSFER: begin
        // Leading edge has priority; a simultaneous trailing pulse is dropped.
        if (lead_edge) begin
          if (CPHA) begin
            mosi_d  = tx_sr_q[DATA_WIDTH-1];
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          end else begin
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], misoIn};
          end
        end else if (trail_edge) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (CPHA) begin
            rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], misoIn};
          end else begin
            mosi_d  = tx_sr_q[DATA_WIDTH-2];
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
          end
          // Stopping on a trailing edge leaves SCLK at its idle level.
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = ST_CS_HOLD;
            sclk_en_d = 1'b0;
            cnt_d     = '0;
          end
        end
      end

      ST_CS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          mosi_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Chip select and busy are registered copies of the next state decode.
    csn_d  = (state_d == ST_IDLE) || (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      csn_q     <= 1'b1;
      sclk_en_q <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      csn_q     <= csn_d;
      sclk_en_q <= sclk_en_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclkEnOut     = sclk_en_q;
  assign csnOut        = csn_q;
  assign mosiOut       = mosi_q;
  assign rxDataOut     = rx_data_q;
  assign busyOut       = busy_q;
  assign doneOut       = done_q;
  assign dbg_state_out = state_q;

endmodule
